p4_router_ingress_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges the per-port, width-converted ingress streams onto the single converged bus feeding the P4 parser. It sits directly downstream of the ingress port array adapter, in the converged-bus clock domain. Each output frame is tagged with its source port in tid. The block enforces MTU by truncating and flagging oversize frames.

---
 rtl/p4_router_pkg.sv | 19 +
 rtl/p4_router_rr_arbiter.sv | 30 +++
 rtl/p4_router_ingress_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_p4_router_ingress_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared types and constants for the P4 router ingress/egress arbitration blocks.
package p4_router_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    PASS    = 2'd1,
    DISCARD = 2'd2
  } arb_state_e;

  localparam int unsigned TUSER_TRUNC_BIT = 0;
  localparam int unsigned TUSER_WIDTH     = 1;
  localparam int unsigned TDEST_WIDTH     = 1;

  // Port-index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p4_router_rr_arbiter.sv
// Combinational rotating-priority grant: first requester above last_grant, wrapping modulo NUM_REQ.
module p4_router_rr_arbiter
  import p4_router_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid_c,
  output logic [IDX_W-1:0]   grant_idx_c
);

  logic found;

  always_comb begin
    found       = 1'b0;
    grant_idx_c = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((32'(last_grant) + off) % NUM_REQ))) begin
          found       = 1'b1;
          grant_idx_c = IDX_W'(j);
        end
      end
    end
    grant_valid_c = found;
  end

endmodule

// File: rtl/p4_router_ingress_arbiter.sv
// Packet-level round-robin merge of per-port ingress streams onto the converged parser bus,
// tagging source port in tid and truncating/flagging frames that exceed MTU_BYTES.
module p4_router_ingress_arbiter
  import p4_router_pkg::*;
#(
  parameter  int unsigned NUM_ING_PHYS_PORTS       = 4,
  parameter  int unsigned CONVERGED_BUS_DATA_BYTES = 8,
  parameter  int unsigned MTU_BYTES                = 1500,
  parameter  int unsigned CNT_WIDTH                = 32,
  localparam int unsigned N      = NUM_ING_PHYS_PORTS,
  localparam int unsigned DB     = CONVERGED_BUS_DATA_BYTES,
  localparam int unsigned DW     = DB * 8,
  localparam int unsigned IDX_W  = idx_width(NUM_ING_PHYS_PORTS),
  localparam int unsigned BCNT_W = $clog2(MTU_BYTES + CONVERGED_BUS_DATA_BYTES + 1),
  localparam int unsigned KCNT_W = $clog2(CONVERGED_BUS_DATA_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         sresetn,
  input  logic [N-1:0][DW-1:0]         ing_ports_adapted_tdata,
  input  logic [N-1:0][DB-1:0]         ing_ports_adapted_tkeep,
  input  logic [N-1:0]                 ing_ports_adapted_tlast,
  input  logic [N-1:0]                 ing_ports_adapted_tvalid,
  output logic [N-1:0]                 ing_ports_adapted_tready,
  output logic [DW-1:0]                arb_out_tdata,
  output logic [DB-1:0]                arb_out_tkeep,
  output logic [DB-1:0]                arb_out_tstrb,
  output logic                         arb_out_tlast,
  output logic [IDX_W-1:0]             arb_out_tid,
  output logic [TDEST_WIDTH-1:0]       arb_out_tdest,
  output logic [TUSER_WIDTH-1:0]       arb_out_tuser,
  output logic                         arb_out_tvalid,
  input  logic                         arb_out_tready,
  output logic [N-1:0][CNT_WIDTH-1:0]  oversize_cnts,
  input  logic [N-1:0]                 oversize_cnts_clear,
  output logic [IDX_W-1:0]             active_port,
  output logic                         busy
);

  if (NUM_ING_PHYS_PORTS == 0 || CONVERGED_BUS_DATA_BYTES == 0) begin : g_param_chk
    $error("p4_router_ingress_arbiter: port count and bus width must be non-zero");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_nxt;
  logic [KCNT_W-1:0]   keep_cnt;
  logic                grant_valid, load_en, over;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_load, pass_fire, frame_end, trunc;
  logic [DW-1:0]       sel_tdata;
  logic [DB-1:0]       sel_tkeep;
  logic                sel_tlast, sel_tvalid;

  p4_router_rr_arbiter #(.NUM_REQ(N)) u_rr (
    .req           (ing_ports_adapted_tvalid),
    .last_grant    (last_grant_q),
    .grant_valid_c (grant_valid),
    .grant_idx_c   (grant_idx)
  );

  // Output register accepts a new beat when empty or being drained.
  assign load_en = !arb_out_tvalid || arb_out_tready;

  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_tvalid = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (IDX_W'(j) == active_port) begin
        sel_tdata  = ing_ports_adapted_tdata[j];
        sel_tkeep  = ing_ports_adapted_tkeep[j];
        sel_tlast  = ing_ports_adapted_tlast[j];
        sel_tvalid = ing_ports_adapted_tvalid[j];
      end
    end
  end

  always_comb begin
    keep_cnt = '0;
    for (int unsigned j = 0; j < DB; j++) begin
      keep_cnt = keep_cnt + KCNT_W'(sel_tkeep[j]);
    end
  end

  assign byte_cnt_nxt = byte_cnt_q + BCNT_W'(keep_cnt);
  assign over         = byte_cnt_nxt > BCNT_W'(MTU_BYTES);

  always_ff @(posedge clk) begin
    if (!sresetn) state_q <= ARB;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d                  = state_q;
    ing_ports_adapted_tready = '0;
    grant_load               = 1'b0;
    pass_fire                = 1'b0;
    frame_end                = 1'b0;
    trunc                    = 1'b0;
    case (state_q)
      ARB: begin
        if (grant_valid) begin
          grant_load = 1'b1;
          state_d    = PASS;
        end
      end
      PASS: begin
        for (int unsigned j = 0; j < N; j++) begin
          ing_ports_adapted_tready[j] = (IDX_W'(j) == active_port) && load_en;
        end
        pass_fire = sel_tvalid && load_en;
        if (pass_fire) begin
          if (over) begin
            trunc = 1'b1;
            if (sel_tlast) begin
              frame_end = 1'b1;
              state_d   = ARB;
            end else begin
              state_d   = DISCARD;
            end
          end else if (sel_tlast) begin
            frame_end = 1'b1;
            state_d   = ARB;
          end
        end
      end
      DISCARD: begin
        for (int unsigned j = 0; j < N; j++) begin
          ing_ports_adapted_tready[j] = (IDX_W'(j) == active_port);
        end
        if (sel_tvalid && sel_tlast) begin
          frame_end = 1'b1;
          state_d   = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      last_grant_q <= IDX_W'(N - 1);
      active_port  <= '0;
      byte_cnt_q   <= '0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_d != ARB);
      if (grant_load) begin
        active_port <= grant_idx;
        byte_cnt_q  <= '0;
      end
      if (pass_fire) byte_cnt_q   <= byte_cnt_nxt;
      if (frame_end) last_grant_q <= active_port;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn)     arb_out_tvalid <= 1'b0;
    else if (load_en) arb_out_tvalid <= pass_fire;
  end

  // Truncated beats are closed with tlast so the parser sees a well-formed frame.
  always_ff @(posedge clk) begin
    if (pass_fire) begin
      arb_out_tdata                  <= sel_tdata;
      arb_out_tkeep                  <= sel_tkeep;
      arb_out_tlast                  <= sel_tlast | over;
      arb_out_tid                    <= active_port;
      arb_out_tuser                  <= '0;
      arb_out_tuser[TUSER_TRUNC_BIT] <= over;
    end
  end

  assign arb_out_tstrb = arb_out_tkeep;
  assign arb_out_tdest = '0;

  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!sresetn)                                                  cnt_q <= '0;
      else if (oversize_cnts_clear[g])                               cnt_q <= '0;
      else if (trunc && (active_port == IDX_W'(g)) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
    assign oversize_cnts[g] = cnt_q;
  end

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
// Directed self-checking bench for p4_router_ingress_arbiter (4 ports, 8-byte bus, 64-byte MTU).
module tb_p4_router_ingress_arbiter;
  import p4_router_pkg::*;

  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int DW  = 64;
  localparam int MTU = 64;
  localparam int CW  = 8;
  localparam int IW  = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic        user;
    logic [31:0] cyc;
  } obeat_t;

  logic                        clk;
  logic                        sresetn;
  logic [N-1:0][DW-1:0]        in_tdata;
  logic [N-1:0][DB-1:0]        in_tkeep;
  logic [N-1:0]                in_tlast;
  logic [N-1:0]                in_tvalid;
  logic [N-1:0]                in_tready;
  logic [DW-1:0]               out_tdata;
  logic [DB-1:0]               out_tkeep;
  logic [DB-1:0]               out_tstrb;
  logic                        out_tlast;
  logic [IW-1:0]               out_tid;
  logic [TDEST_WIDTH-1:0]      out_tdest;
  logic [TUSER_WIDTH-1:0]      out_tuser;
  logic                        out_tvalid;
  logic                        out_tready;
  logic [N-1:0][CW-1:0]        cnts;
  logic [N-1:0]                cnts_clear;
  logic [IW-1:0]               active_port;
  logic                        busy;

  p4_router_ingress_arbiter #(
    .NUM_ING_PHYS_PORTS       (N),
    .CONVERGED_BUS_DATA_BYTES (DB),
    .MTU_BYTES                (MTU),
    .CNT_WIDTH                (CW)
  ) dut (
    .clk                      (clk),
    .sresetn                  (sresetn),
    .ing_ports_adapted_tdata  (in_tdata),
    .ing_ports_adapted_tkeep  (in_tkeep),
    .ing_ports_adapted_tlast  (in_tlast),
    .ing_ports_adapted_tvalid (in_tvalid),
    .ing_ports_adapted_tready (in_tready),
    .arb_out_tdata            (out_tdata),
    .arb_out_tkeep            (out_tkeep),
    .arb_out_tstrb            (out_tstrb),
    .arb_out_tlast            (out_tlast),
    .arb_out_tid              (out_tid),
    .arb_out_tdest            (out_tdest),
    .arb_out_tuser            (out_tuser),
    .arb_out_tvalid           (out_tvalid),
    .arb_out_tready           (out_tready),
    .oversize_cnts            (cnts),
    .oversize_cnts_clear      (cnts_clear),
    .active_port              (active_port),
    .busy                     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       src_q [N][$];
  obeat_t      out_q [$];
  obeat_t      exp_q [$];
  logic [N-1:0] fire;
  logic        rst_n_req, rst_prev, rand_rdy, stalled_prev;
  logic [75:0] held_pl;
  int          cyc;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later; handshakes sampled here complete at the next posedge.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < N; p++)
      if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    rst_prev   = sresetn;
    sresetn    = rst_n_req;
    out_tready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        in_tvalid[p] = 1'b1;
        in_tdata[p]  = src_q[p][0].data;
        in_tkeep[p]  = src_q[p][0].keep;
        in_tlast[p]  = src_q[p][0].last;
      end else begin
        in_tvalid[p] = 1'b0;
        in_tdata[p]  = '0;
        in_tkeep[p]  = '0;
        in_tlast[p]  = 1'b0;
      end
    end
    #1;
    for (int p = 0; p < N; p++) fire[p] = in_tvalid[p] && in_tready[p];
    if (stalled_prev && rst_prev) begin
      check("stall_valid", out_tvalid, 1'b1);
      check("stall_payload", {out_tdata, out_tkeep, out_tlast, out_tid, out_tuser}, held_pl);
    end
    if (out_tvalid && out_tready)
      out_q.push_back({out_tdata, out_tkeep, out_tlast, out_tid, out_tuser[TUSER_TRUNC_BIT], 32'(cyc)});
    stalled_prev = out_tvalid && !out_tready;
    held_pl      = {out_tdata, out_tkeep, out_tlast, out_tid, out_tuser};
    cyc++;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n_req = 1'b0;
    for (int p = 0; p < N; p++) src_q[p].delete();
    repeat (cycles) step();
    rst_n_req = 1'b1;
  endtask

  function automatic obeat_t mk_exp(input beat_t bt, input int p, input logic last, input logic user);
    return {bt.data, bt.keep, last, 2'(p), user, 32'd0};
  endfunction

  // Queue a frame; the first fwd beats are expected out, the last of them flagged with trunc.
  task automatic push_frame(input int p, input int nbytes, input logic [7:0] tag,
                            input int fwd, input logic trunc);
    int nb;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      int    rem;
      rem     = nbytes - 8 * b;
      bt.data = {tag, 8'(p), 8'(b), 40'h5AA50FF03C};
      bt.keep = (rem >= 8) ? 8'hFF : 8'(8'hFF >> (8 - rem));
      bt.last = (b == nb - 1);
      src_q[p].push_back(bt);
      if (b < fwd) exp_q.push_back(mk_exp(bt, p, b == fwd - 1, trunc && (b == fwd - 1)));
    end
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (out_q.size() < n && b < budget) begin
      step();
      b++;
    end
    check({tag, "_done"}, out_q.size() >= n, 1'b1);
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i),
            {out_q[i].data, out_q[i].keep, out_q[i].last, out_q[i].id, out_q[i].user},
            {exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].id, exp_q[i].user});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    beat_t bt;
    n_tests = 0; n_fail = 0; cyc = 0;
    fire = '0; rand_rdy = 1'b0; stalled_prev = 1'b0; held_pl = '0;
    sresetn = 1'b0; rst_prev = 1'b0; rst_n_req = 1'b0;
    in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
    out_tready = 1'b1; cnts_clear = '0;

    // Reset state
    apply_reset(3);
    check("rst_tvalid", out_tvalid, 1'b0);
    check("rst_tready", in_tready, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_active_port", active_port, 2'd0);
    check("rst_cnts", cnts, 32'd0);

    // Single 64 B frame on port 0, first beat two cycles after tvalid
    out_q.delete(); exp_q.delete();
    c0 = cyc;
    push_frame(0, 64, 8'h11, 8, 1'b0);
    run_until("single", 8, 40);
    repeat (4) step();
    compare_out("single");
    if (out_q.size() > 0) begin
      check("single_latency", out_q[0].cyc - 32'(c0), 32'd2);
      check("single_tstrb", out_tstrb, out_tkeep);
    end
    check("single_tdest", out_tdest, 1'b0);
    check("single_busy_idle", busy, 1'b0);

    // All four ports continuously valid with 2-beat frames: grant 0,1,2,3,0,1,2,3
    apply_reset(2);
    out_q.delete(); exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_frame(p, 16, 8'(8'h20 + r), 2, 1'b0);
    run_until("rr", 16, 200);
    repeat (4) step();
    compare_out("rr");
    if (out_q.size() >= 16) begin
      for (int k = 1; k < 8; k++)
        check($sformatf("rr_bubble%0d", k), out_q[2*k].cyc - out_q[2*k-1].cyc, 32'd2);
      for (int k = 0; k < 8; k++)
        check($sformatf("rr_stream%0d", k), out_q[2*k+1].cyc - out_q[2*k].cyc, 32'd1);
    end

    // Oversize 80 B on port 2: beat 9 crosses 64 B, is flagged and closes the frame; beat 10 dropped
    out_q.delete(); exp_q.delete();
    push_frame(2, 80, 8'h33, 9, 1'b1);
    run_until("over", 9, 60);
    repeat (10) step();
    compare_out("over");
    check("over_consumed", src_q[2].size(), 0);
    check("over_cnt2", cnts[2], 8'd1);
    check("over_cnt0", cnts[0], 8'd0);
    check("over_busy_idle", busy, 1'b0);

    cnts_clear[2] = 1'b1;
    step();
    cnts_clear[2] = 1'b0;
    step();
    check("clear_cnt2", cnts[2], 8'd0);

    // Exact 64 B across 9 beats with partial tkeep at both ends passes untruncated
    out_q.delete(); exp_q.delete();
    for (int b = 0; b < 9; b++) begin
      bt.data = {8'hE5, 8'd3, 8'(b), 40'h0};
      bt.keep = (b == 0 || b == 8) ? 8'h0F : 8'hFF;
      bt.last = (b == 8);
      src_q[3].push_back(bt);
      exp_q.push_back(mk_exp(bt, 3, bt.last, 1'b0));
    end
    run_until("mtu", 9, 60);
    repeat (4) step();
    compare_out("mtu");
    check("mtu_cnt3", cnts[3], 8'd0);

    // 65 B ends with tlast while over MTU; clear held through the frame beats the increment
    out_q.delete(); exp_q.delete();
    cnts_clear[1] = 1'b1;
    push_frame(1, 65, 8'h44, 9, 1'b1);
    run_until("mtu1_clr", 9, 60);
    repeat (4) step();
    cnts_clear[1] = 1'b0;
    compare_out("mtu1_clr");
    check("clr_prio_cnt1", cnts[1], 8'd0);

    out_q.delete(); exp_q.delete();
    push_frame(1, 65, 8'h45, 9, 1'b1);
    run_until("mtu1", 9, 60);
    repeat (4) step();
    compare_out("mtu1");
    check("mtu1_cnt1", cnts[1], 8'd1);

    // Random 30% output ready, mixed frame sizes, expected order 0,1,3,0,1,3
    apply_reset(2);
    out_q.delete(); exp_q.delete();
    push_frame(0, 24, 8'h50, 3, 1'b0);
    push_frame(1, 40, 8'h51, 5, 1'b0);
    push_frame(3,  8, 8'h52, 1, 1'b0);
    push_frame(0, 13, 8'h53, 2, 1'b0);
    push_frame(1, 64, 8'h54, 8, 1'b0);
    push_frame(3, 30, 8'h55, 4, 1'b0);
    rand_rdy = 1'b1;
    run_until("rand", 23, 600);
    rand_rdy = 1'b0;
    repeat (4) step();
    compare_out("rand");

    // Reset in the middle of a port 2 frame
    apply_reset(2);
    out_q.delete(); exp_q.delete();
    push_frame(1, 80, 8'h60, 9, 1'b1);
    run_until("pre_rst", 9, 60);
    repeat (6) step();
    check("pre_rst_cnt1", cnts[1], 8'd1);
    push_frame(2, 48, 8'h61, 6, 1'b0);
    push_frame(3, 16, 8'h62, 2, 1'b0);
    run_until("mid_frame", 11, 40);
    rst_n_req = 1'b0;
    for (int p = 0; p < N; p++) src_q[p].delete();
    step();
    step();
    check("midrst_tvalid", out_tvalid, 1'b0);
    check("midrst_tready", in_tready, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cnts", cnts, 32'd0);
    rst_n_req = 1'b1;
    out_q.delete(); exp_q.delete();
    push_frame(0, 16, 8'h70, 2, 1'b0);
    push_frame(3, 16, 8'h71, 2, 1'b0);
    run_until("post_rst", 4, 50);
    repeat (4) step();
    compare_out("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
